// File: rtl/norm_arbiter.sv
// rtl/norm_arbiter.sv - two-requester round-robin normalizer sharing one LZ counter and shifter
// Optional NORM_UNDERFLOW_EN: clamps out_exp at 0 on exponent underflow and adds out_uflow.
module norm_arbiter #(
  parameter int DATA_W = 8,
  parameter int EXP_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in0_valid,
  output logic                      in0_ready,
  input  logic [DATA_W-1:0]         in0_mant,
  input  logic [EXP_W-1:0]          in0_exp,
  input  logic                      in1_valid,
  output logic                      in1_ready,
  input  logic [DATA_W-1:0]         in1_mant,
  input  logic [EXP_W-1:0]          in1_exp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_mant,
  output logic [EXP_W-1:0]          out_exp,
  output logic [$clog2(DATA_W):0]   out_lz,
  output logic                      out_zero,
  output logic                      out_src
`ifdef NORM_UNDERFLOW_EN
  ,
  output logic                      out_uflow
`endif
);

  localparam int LZ_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                ptr_q;
  logic                grant_any;
  logic                grant_sel;
  logic                handshake;
  logic [DATA_W-1:0]   mant_q;
  logic [EXP_W-1:0]    exp_q;
  logic                src_q;

  logic [LZ_W-1:0]     lz_c;
  logic                found;
  logic [DATA_W-1:0]   mant_norm;
  logic [EXP_W-1:0]    exp_norm;
  logic                is_zero;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant_any = in0_valid | in1_valid;
    if (in0_valid && in1_valid) begin
      grant_sel = ptr_q;
    end else begin
      grant_sel = in1_valid;
    end
  end

  assign handshake = (state_q == ST_IDLE) && grant_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_any) state_d = ST_CALC;
      ST_CALC: state_d = ST_OUT;
      ST_OUT:  if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in0_ready = grant_any & ~grant_sel;
        in1_ready = grant_any &  grant_sel;
      end
      ST_OUT:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Single leading-zero counter over the captured mantissa.
  always_comb begin
    lz_c  = LZ_W'(DATA_W);
    found = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (!found && mant_q[i]) begin
        lz_c  = LZ_W'(DATA_W - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign is_zero   = ~found;
  assign mant_norm = mant_q << lz_c;

`ifdef NORM_UNDERFLOW_EN
  localparam int DW = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;
  logic [DW-1:0] diff;
  logic          uflow_c;

  // Extra top bit of the difference is the borrow, i.e. exp < lz.
  assign diff    = DW'(exp_q) - DW'(lz_c);
  assign uflow_c = ~is_zero & diff[DW-1];

  always_comb begin
    exp_norm = diff[EXP_W-1:0];
    if (is_zero || uflow_c) exp_norm = '0;
  end
`else
  always_comb begin
    exp_norm = exp_q - EXP_W'(lz_c);
    if (is_zero) exp_norm = '0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= 1'b0;
      mant_q    <= '0;
      exp_q     <= '0;
      src_q     <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_lz    <= '0;
      out_zero  <= 1'b0;
      out_src   <= 1'b0;
`ifdef NORM_UNDERFLOW_EN
      out_uflow <= 1'b0;
`endif
    end else begin
      if (handshake) begin
        ptr_q  <= ~grant_sel;
        mant_q <= grant_sel ? in1_mant : in0_mant;
        exp_q  <= grant_sel ? in1_exp  : in0_exp;
        src_q  <= grant_sel;
      end
      if (state_q == ST_CALC) begin
        out_mant  <= mant_norm;
        out_exp   <= exp_norm;
        out_lz    <= lz_c;
        out_zero  <= is_zero;
        out_src   <= src_q;
`ifdef NORM_UNDERFLOW_EN
        out_uflow <= uflow_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_norm_arbiter.sv
// tb/tb_norm_arbiter.sv - directed vector bench for norm_arbiter (DATA_W=8, EXP_W=8)
module tb_norm_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in0_valid, in1_valid;
  logic       in0_ready, in1_ready;
  logic [7:0] in0_mant, in1_mant;
  logic [7:0] in0_exp, in1_exp;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mant;
  logic [7:0] out_exp;
  logic [3:0] out_lz;
  logic       out_zero;
  logic       out_src;
`ifdef NORM_UNDERFLOW_EN
  logic       out_uflow;
`endif

  norm_arbiter #(.DATA_W(8), .EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_mant(in0_mant), .in0_exp(in0_exp),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_mant(in1_mant), .in1_exp(in1_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
    .out_lz(out_lz), .out_zero(out_zero), .out_src(out_src)
`ifdef NORM_UNDERFLOW_EN
    , .out_uflow(out_uflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       src;
    logic [7:0] mant;
    logic [7:0] exp;
    logic [7:0] e_mant;
    logic [7:0] e_exp;
    logic       e_uflow;
    logic [3:0] e_lz;
    logic       e_zero;
  } vec_t;

  vec_t vecs[9];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    // {src, mant, exp, exp_mant, exp_exp(modulo), uflow, lz, zero}
    vecs[0] = '{1'b0, 8'h10, 8'd20,  8'h80, 8'd17,  1'b0, 4'd3, 1'b0};
    vecs[1] = '{1'b1, 8'h00, 8'd50,  8'h00, 8'd0,   1'b0, 4'd8, 1'b1};
    vecs[2] = '{1'b0, 8'h01, 8'd3,   8'h80, 8'hFC,  1'b1, 4'd7, 1'b0};
    vecs[3] = '{1'b1, 8'h80, 8'd5,   8'h80, 8'd5,   1'b0, 4'd0, 1'b0};
    vecs[4] = '{1'b0, 8'h03, 8'd255, 8'hC0, 8'd249, 1'b0, 4'd6, 1'b0};
    vecs[5] = '{1'b1, 8'h40, 8'd0,   8'h80, 8'hFF,  1'b1, 4'd1, 1'b0};
    vecs[6] = '{1'b0, 8'h01, 8'd7,   8'h80, 8'd0,   1'b0, 4'd7, 1'b0};
    vecs[7] = '{1'b1, 8'h2B, 8'd10,  8'hAC, 8'd8,   1'b0, 4'd2, 1'b0};
    vecs[8] = '{1'b0, 8'hFF, 8'd0,   8'hFF, 8'd0,   1'b0, 4'd0, 1'b0};

    rst_n = 1'b0; out_ready = 1'b1;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_mant = '0; in0_exp = '0; in1_mant = '0; in1_exp = '0;

    // Reset state
    @(negedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_mant",  32'(out_mant), 0);
    check("rst_out_exp",   32'(out_exp), 0);
    check("rst_out_lz",    32'(out_lz), 0);
    check("rst_out_zero",  32'(out_zero), 0);
    check("rst_out_src",   32'(out_src), 0);
    @(negedge clk); rst_n = 1'b1;

    // Round robin with both requesters always valid
    @(negedge clk);
    in0_valid = 1'b1; in0_mant = 8'h10; in0_exp = 8'd20;
    in1_valid = 1'b1; in1_mant = 8'h01; in1_exp = 8'd9;
    #1;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("rr%0d_in0_ready", g), 32'(in0_ready), 32'(g % 2 == 0));
      check($sformatf("rr%0d_in1_ready", g), 32'(in1_ready), 32'(g % 2 == 1));
      @(negedge clk); #1;
      check($sformatf("rr%0d_calc_ready", g), 32'({in0_ready, in1_ready}), 0);
      check($sformatf("rr%0d_calc_valid", g), 32'(out_valid), 0);
      @(negedge clk); #1;
      check($sformatf("rr%0d_out_valid", g), 32'(out_valid), 1);
      check($sformatf("rr%0d_out_src", g), 32'(out_src), 32'(g % 2));
      check($sformatf("rr%0d_out_exp", g), 32'(out_exp), (g % 2 == 0) ? 17 : 2);
      @(negedge clk); #1;
    end
    in0_valid = 1'b0; in1_valid = 1'b0;

    // Table vectors, one requester at a time
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].src) begin
        in1_valid = 1'b1; in1_mant = vecs[i].mant; in1_exp = vecs[i].exp;
      end else begin
        in0_valid = 1'b1; in0_mant = vecs[i].mant; in0_exp = vecs[i].exp;
      end
      #1;
      check($sformatf("v%0d_ready", i), 32'({in1_ready, in0_ready}), vecs[i].src ? 2 : 1);
      @(negedge clk);
      in0_valid = 1'b0; in1_valid = 1'b0;
      #1;
      check($sformatf("v%0d_calc_ready", i), 32'({in0_ready, in1_ready}), 0);
      check($sformatf("v%0d_calc_valid", i), 32'(out_valid), 0);
      @(negedge clk); #1;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 1);
      check($sformatf("v%0d_out_mant", i), 32'(out_mant), 32'(vecs[i].e_mant));
      check($sformatf("v%0d_out_lz", i), 32'(out_lz), 32'(vecs[i].e_lz));
      check($sformatf("v%0d_out_zero", i), 32'(out_zero), 32'(vecs[i].e_zero));
      check($sformatf("v%0d_out_src", i), 32'(out_src), 32'(vecs[i].src));
`ifdef NORM_UNDERFLOW_EN
      check($sformatf("v%0d_out_exp", i), 32'(out_exp), vecs[i].e_uflow ? 0 : 32'(vecs[i].e_exp));
      check($sformatf("v%0d_out_uflow", i), 32'(out_uflow), 32'(vecs[i].e_uflow));
`else
      check($sformatf("v%0d_out_exp", i), 32'(out_exp), 32'(vecs[i].e_exp));
`endif
      @(negedge clk); #1;
      check($sformatf("v%0d_back_idle", i), 32'(out_valid), 0);
    end

    // Backpressure hold in OUT, then asynchronous reset mid-transaction
    out_ready = 1'b0;
    in0_valid = 1'b1; in0_mant = 8'h10; in0_exp = 8'd20;
    @(negedge clk);
    in0_valid = 1'b0;
    in1_valid = 1'b1; in1_mant = 8'h20; in1_exp = 8'd4;
    #1;
    check("hold_calc_ready", 32'({in0_ready, in1_ready}), 0);
    @(negedge clk); #1;
    check("hold_out_valid", 32'(out_valid), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check($sformatf("hold%0d_valid", c), 32'(out_valid), 1);
      check($sformatf("hold%0d_ready", c), 32'({in0_ready, in1_ready}), 0);
      check($sformatf("hold%0d_fields", c), {11'd0, out_src, out_zero, out_lz, out_exp, out_mant},
            {11'd0, 1'b0, 1'b0, 4'd3, 8'd17, 8'h80});
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_mant", 32'(out_mant), 0);
    check("arst_out_exp", 32'(out_exp), 0);
    check("arst_out_lz", 32'(out_lz), 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    in0_valid = 1'b1; in0_mant = 8'h04; in0_exp = 8'd9;
    #1;
    check("post_rst_no_output", 32'(out_valid), 0);
    check("post_rst_ptr_in0", 32'({in1_ready, in0_ready}), 1);
    @(negedge clk);
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(negedge clk); #1;
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_src", 32'(out_src), 0);
    check("post_rst_mant", 32'(out_mant), 32'h80);
    check("post_rst_exp", 32'(out_exp), 4);
    @(negedge clk); #1;
    check("post_rst_idle", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/norm_arbiter.md
NORM_ARBITER -- requirements
Module: norm_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8: mantissa width in bits (power of two, at least 4).
REQ-002 SHALL have parameter EXP_W, default 8: unsigned exponent width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ports in0_valid and in1_valid, input, 1 bit each: requester k offers an operand.
REQ-006 SHALL have ports in0_ready and in1_ready, output, 1 bit each: requester k's operand is accepted this cycle.
REQ-007 SHALL have ports in0_mant and in1_mant, input, DATA_W bits each: unnormalized mantissa.
REQ-008 SHALL have ports in0_exp and in1_exp, input, EXP_W bits each: unsigned exponent.
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port out_mant, output, DATA_W bits: normalized mantissa, MSB set unless zero.
REQ-012 SHALL have port out_exp, output, EXP_W bits: adjusted exponent.
REQ-013 SHALL have port out_lz, output, $clog2(DATA_W)+1 bits: leading-zero count applied.
REQ-014 SHALL have port out_zero, output, 1 bit: input mantissa was all zeros.
REQ-015 SHALL have port out_src, output, 1 bit: index of the originating requester.

Function
REQ-016 SHALL share one leading-zero counter and one left shifter between both requesters.
REQ-017 SHALL implement FSM IDLE -> CALC -> OUT -> IDLE.
REQ-018 In IDLE, SHALL grant one valid requester; in_k_ready = (state==IDLE) & grant_k, so a handshake occurs when valid and ready are both high.
REQ-019 Arbitration SHALL be round-robin: one 1-bit pointer names the favoured requester; after each grant it points to the other requester.
REQ-020 On simultaneous valids, SHALL grant the pointer's requester; a lone valid SHALL be granted regardless of the pointer.
REQ-021 On handshake, SHALL register mantissa, exponent and source, then move to CALC; with no valid, SHALL remain in IDLE.
REQ-022 In CALC (exactly 1 cycle), SHALL compute lz = count of leading zeros in [0, DATA_W], out_mant = mant << lz, out_exp = exp - lz, register them, then move to OUT.
REQ-023 All-zero mantissa SHALL give out_zero=1, out_lz=DATA_W, out_mant=0, out_exp=0, with no underflow.
REQ-024 In OUT, out_valid=1 and all out_* SHALL hold stable until out_ready=1, then return to IDLE next cycle.
REQ-025 Latency SHALL be 2 cycles from input handshake edge to out_valid=1; throughput SHALL be at most 1 result per 3 cycles.
REQ-026 in0_ready and in1_ready SHALL be 0 in CALC and OUT, and never both 1.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, pointer=requester 0, out_valid=0, out_mant=0, out_exp=0, out_lz=0, out_zero=0, out_src=0, and out_uflow=0 if present.
REQ-028 Reset during CALC or OUT SHALL discard the transaction with no output produced.

Configuration
REQ-029 Macro NORM_UNDERFLOW_EN defined: SHALL provide output out_uflow (1 bit); when exp < lz for a nonzero mantissa, out_exp=0 and out_uflow=1, else out_uflow=0.
REQ-030 Macro NORM_UNDERFLOW_EN undefined: out_uflow SHALL not exist, and out_exp SHALL equal (exp - lz) modulo 2^EXP_W.

Verification (DATA_W=8, EXP_W=8)
REQ-031 After reset, in0 mant=0x10 exp=20 -> 2 cycles later out_valid=1, out_mant=0x80, out_exp=17, out_lz=3, out_src=0.
REQ-032 After reset, both valid continuously with out_ready=1 -> grants alternate 0,1,0,1 with out_src following; one result per 3 cycles.
REQ-033 in1 mant=0x00 exp=50 -> out_zero=1, out_mant=0, out_exp=0, out_lz=8, out_src=1.
REQ-034 in0 mant=0x01 exp=3 -> out_lz=7; with macro: out_exp=0, out_uflow=1; without macro: out_exp=0xFC.
REQ-035 out_ready held 0 for 5 cycles in OUT -> outputs stable and both in_ready=0; then rst_n pulsed low -> out_valid=0 immediately, next grant goes to in0.
